// File: rtl/axis_flit_injector_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_flit_injector_if
// Brief    : AXI-stream slave plus credit-based flit output bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface axis_flit_injector_if #(
    parameter int TDATA_WIDTH          = 32,
    parameter int TDEST_WIDTH          = 4,
    parameter int TID_WIDTH            = 2,
    parameter int SERIALIZATION_FACTOR = 1
);
    localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
    localparam int DEST_WIDTH = TDEST_WIDTH + TID_WIDTH;

    logic                   axis_in_tvalid;
    logic [TDATA_WIDTH-1:0] axis_in_tdata;
    logic                   axis_in_tlast;
    logic [TID_WIDTH-1:0]   axis_in_tid;
    logic [TDEST_WIDTH-1:0] axis_in_tdest;
    logic                   axis_in_tready;
    logic [FLIT_WIDTH-1:0]  data_out;
    logic [DEST_WIDTH-1:0]  dest_out;
    logic                   is_tail_out;
    logic                   send_out;
    logic                   credit_in;

    modport slave (
        input  axis_in_tvalid, axis_in_tdata, axis_in_tlast, axis_in_tid,
               axis_in_tdest, credit_in,
        output axis_in_tready, data_out, dest_out, is_tail_out, send_out
    );

    modport master (
        output axis_in_tvalid, axis_in_tdata, axis_in_tlast, axis_in_tid,
               axis_in_tdest, credit_in,
        input  axis_in_tready, data_out, dest_out, is_tail_out, send_out
    );
endinterface
`default_nettype wire

// File: rtl/axis_flit_injector.sv
`default_nettype none
// ============================================================================
// Module   : axis_flit_injector
// Brief    : Serialises AXI-stream beats into credit-flow-controlled NoC flits.
//            Define AXIS_FLIT_INJECTOR_STATS_EN to add flit/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module axis_flit_injector #(
    parameter int TDATA_WIDTH          = 32,
    parameter int TDEST_WIDTH          = 4,
    parameter int TID_WIDTH            = 2,
    parameter int SERIALIZATION_FACTOR = 1,
    parameter int FLIT_BUFFER_DEPTH    = 1
) (
    input  wire         clk_noc,
    input  wire         rst_noc,
`ifdef AXIS_FLIT_INJECTOR_STATS_EN
    output logic [31:0] stat_flits_sent,
    output logic [31:0] stat_stall_cycles,
`endif
    axis_flit_injector_if.slave bus
);
    localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
    localparam int DEST_WIDTH = TDEST_WIDTH + TID_WIDTH;
    localparam int c_IDX_W    = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
    localparam int c_CREDIT_W = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam logic [c_CREDIT_W-1:0] c_CREDIT_MAX = c_CREDIT_W'(FLIT_BUFFER_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_SERIAL = 1'b1
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [c_IDX_W-1:0]      r_index, w_index_nxt;
    logic [c_CREDIT_W-1:0]   r_credit, w_credit_nxt;
    logic [TDATA_WIDTH-1:0]  r_beat;
    logic                    r_beat_last;
    logic [DEST_WIDTH-1:0]   r_beat_dest;
    logic                    r_send;
    logic [FLIT_WIDTH-1:0]   r_data_out;
    logic [DEST_WIDTH-1:0]   r_dest_out;
    logic                    r_tail;
    logic [FLIT_WIDTH-1:0]   w_flit;
    logic                    w_last_flit;
    logic                    w_launch;
    logic                    w_ready;
    logic                    w_accept;

    assign w_launch = (r_state == S_SERIAL) && (r_credit != '0);
    assign w_ready  = (r_state == S_IDLE) || (w_launch && w_last_flit);
    assign w_accept = bus.axis_in_tvalid && w_ready;

    assign bus.axis_in_tready = w_ready;
    assign bus.send_out       = r_send;
    assign bus.data_out       = r_data_out;
    assign bus.dest_out       = r_dest_out;
    assign bus.is_tail_out    = r_tail;

    generate
        if (SERIALIZATION_FACTOR > 1) begin : g_multi
            logic [SERIALIZATION_FACTOR-1:0][FLIT_WIDTH-1:0] w_slices;
            assign w_slices    = r_beat;
            assign w_flit      = w_slices[r_index];
            assign w_last_flit = (r_index == c_IDX_W'(SERIALIZATION_FACTOR - 1));
        end else begin : g_single
            assign w_flit      = r_beat;
            assign w_last_flit = (r_index == '0);
        end
    endgenerate

    always_comb begin
        w_state_nxt  = r_state;
        w_index_nxt  = r_index;
        w_credit_nxt = r_credit;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SERIAL;
                    w_index_nxt = '0;
                end
            end
            S_SERIAL: begin
                if (w_launch) begin
                    if (w_last_flit) begin
                        w_index_nxt = '0;
                        w_state_nxt = w_accept ? S_SERIAL : S_IDLE;
                    end else begin
                        w_index_nxt = r_index + c_IDX_W'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // A launch and a returned credit in the same cycle cancel out.
        if (w_launch && !bus.credit_in) begin
            w_credit_nxt = r_credit - c_CREDIT_W'(1);
        end else if (!w_launch && bus.credit_in && (r_credit != c_CREDIT_MAX)) begin
            w_credit_nxt = r_credit + c_CREDIT_W'(1);
        end
    end

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            r_state  <= S_IDLE;
            r_index  <= '0;
            r_credit <= c_CREDIT_MAX;
        end else begin
            r_state  <= w_state_nxt;
            r_index  <= w_index_nxt;
            r_credit <= w_credit_nxt;
        end
    end

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            r_beat      <= '0;
            r_beat_last <= 1'b0;
            r_beat_dest <= '0;
            r_send      <= 1'b0;
            r_data_out  <= '0;
            r_dest_out  <= '0;
            r_tail      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_beat      <= bus.axis_in_tdata;
                r_beat_last <= bus.axis_in_tlast;
                r_beat_dest <= {bus.axis_in_tid, bus.axis_in_tdest};
            end
            r_send <= w_launch;
            if (w_launch) begin
                r_data_out <= w_flit;
                r_dest_out <= r_beat_dest;
                r_tail     <= r_beat_last && w_last_flit;
            end
        end
    end

`ifdef AXIS_FLIT_INJECTOR_STATS_EN
    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            stat_flits_sent   <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (w_launch) begin
                stat_flits_sent <= stat_flits_sent + 32'd1;
            end
            if ((r_state == S_SERIAL) && (r_credit == '0)) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_flit_injector.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_flit_injector
// Brief    : Self-checking bench: directed vector table, corner sequences and
//            random traffic against a flit-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_flit_injector;
    localparam int TDW   = 32;
    localparam int SF    = 4;
    localparam int DEPTH = 2;

    logic clk_noc = 1'b0;
    logic rst_noc = 1'b1;
    always #5 clk_noc = ~clk_noc;

    axis_flit_injector_if #(
        .TDATA_WIDTH(TDW), .TDEST_WIDTH(4), .TID_WIDTH(2), .SERIALIZATION_FACTOR(SF)
    ) bus ();

`ifdef AXIS_FLIT_INJECTOR_STATS_EN
    wire [31:0] stat_flits_sent;
    wire [31:0] stat_stall_cycles;
`endif

    axis_flit_injector #(
        .TDATA_WIDTH(TDW), .TDEST_WIDTH(4), .TID_WIDTH(2),
        .SERIALIZATION_FACTOR(SF), .FLIT_BUFFER_DEPTH(DEPTH)
    ) dut (
        .clk_noc(clk_noc),
        .rst_noc(rst_noc),
`ifdef AXIS_FLIT_INJECTOR_STATS_EN
        .stat_flits_sent(stat_flits_sent),
        .stat_stall_cycles(stat_stall_cycles),
`endif
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        cr;
        logic        x_rdy;
        logic        x_send;
        logic [7:0]  x_data;
        logic        x_tail;
    } vec_t;
    vec_t vecs [7];

    // Reference model: pending flits of the beat in flight, plus a credit count.
    typedef struct {
        logic [7:0] data;
        logic [5:0] dest;
        logic       tail;
    } flit_t;
    flit_t       mq [$];
    int          m_credit;
    logic        m_send;
    logic [7:0]  m_data;
    logic [5:0]  m_dest;
    logic        m_tail;
    int          n_sent;
    int          n_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: actual %0h required %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_credit = DEPTH;
        m_send   = 1'b0;
        m_data   = '0;
        m_dest   = '0;
        m_tail   = 1'b0;
        n_sent   = 0;
        n_stall  = 0;
    endtask

    function automatic logic model_ready();
        return (mq.size() == 0) || (mq.size() == 1 && m_credit > 0);
    endfunction

    task automatic model_edge(input logic v, input logic [31:0] d, input logic l,
                              input logic [1:0] id, input logic [3:0] de, input logic cr);
        logic  launch;
        logic  acc;
        flit_t f;
        launch = (mq.size() > 0) && (m_credit > 0);
        acc    = v && model_ready();
        if (mq.size() > 0 && m_credit == 0) n_stall++;
        if (launch) begin
            f      = mq.pop_front();
            m_send = 1'b1;
            m_data = f.data;
            m_dest = f.dest;
            m_tail = f.tail;
            n_sent++;
        end else begin
            m_send = 1'b0;
        end
        if (launch && !cr) m_credit--;
        else if (!launch && cr && m_credit < DEPTH) m_credit++;
        if (acc) begin
            for (int k = 0; k < SF; k++) begin
                f.data = d[k*8 +: 8];
                f.dest = {id, de};
                f.tail = l && (k == SF - 1);
                mq.push_back(f);
            end
        end
    endtask

    // Entered and left just after a falling edge; one rising edge in between.
    task automatic cycle(input logic v, input logic [31:0] d, input logic l,
                         input logic [1:0] id, input logic [3:0] de, input logic cr,
                         output logic a_rdy, output logic a_send,
                         output logic [7:0] a_data, output logic a_tail);
        bus.axis_in_tvalid = v;
        bus.axis_in_tdata  = d;
        bus.axis_in_tlast  = l;
        bus.axis_in_tid    = id;
        bus.axis_in_tdest  = de;
        bus.credit_in      = cr;
        #1;
        a_rdy = bus.axis_in_tready;
        chk("tready", a_rdy, model_ready());
        model_edge(v, d, l, id, de, cr);
        @(posedge clk_noc);
        #1;
        a_send = bus.send_out;
        a_data = bus.data_out;
        a_tail = bus.is_tail_out;
        chk("send_out", a_send, m_send);
        chk("data_out", a_data, m_data);
        chk("dest_out", bus.dest_out, m_dest);
        chk("is_tail_out", a_tail, m_tail);
        @(negedge clk_noc);
    endtask

    task automatic drain();
        logic r, s, t;
        logic [7:0] dd;
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b0, 2'd0, 4'd0, 1'b1, r, s, dd, t);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_send"},  bus.send_out, 1'b0);
        chk({tag, "_data"},  bus.data_out, 8'h00);
        chk({tag, "_dest"},  bus.dest_out, 6'h00);
        chk({tag, "_tail"},  bus.is_tail_out, 1'b0);
        chk({tag, "_ready"}, bus.axis_in_tready, 1'b1);
    endtask

    initial begin
        logic r, s, t;
        logic [7:0] dd;
        int cnt_send, cnt_rdy, cnt_acc, cnt_bubble;

        bus.axis_in_tvalid = 1'b0;
        bus.axis_in_tdata  = '0;
        bus.axis_in_tlast  = 1'b0;
        bus.axis_in_tid    = '0;
        bus.axis_in_tdest  = '0;
        bus.credit_in      = 1'b0;
        model_reset();
        rst_noc = 1'b1;
        repeat (3) @(negedge clk_noc);
        check_reset_outputs("reset");
        rst_noc = 1'b0;

        // One tail beat, credit handed back the cycle after each flit.
        vecs[0] = '{1'b1, 32'hDDCCBBAA, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 32'hDDCCBBAA, 1'b1, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b0};
        vecs[2] = '{1'b0, 32'hDDCCBBAA, 1'b1, 1'b1, 1'b0, 1'b1, 8'hBB, 1'b0};
        vecs[3] = '{1'b0, 32'hDDCCBBAA, 1'b1, 1'b1, 1'b0, 1'b1, 8'hCC, 1'b0};
        vecs[4] = '{1'b0, 32'hDDCCBBAA, 1'b1, 1'b1, 1'b1, 1'b1, 8'hDD, 1'b1};
        vecs[5] = '{1'b0, 32'hDDCCBBAA, 1'b1, 1'b1, 1'b1, 1'b0, 8'hDD, 1'b1};
        vecs[6] = '{1'b0, 32'hDDCCBBAA, 1'b1, 1'b0, 1'b1, 1'b0, 8'hDD, 1'b1};
        for (int i = 0; i < 7; i++) begin
            cycle(vecs[i].v, vecs[i].d, vecs[i].l, 2'd1, 4'd5, vecs[i].cr, r, s, dd, t);
            chk($sformatf("vec%0d_rdy", i), r, vecs[i].x_rdy);
            chk($sformatf("vec%0d_send", i), s, vecs[i].x_send);
            if (vecs[i].x_send) chk($sformatf("vec%0d_data", i), dd, vecs[i].x_data);
            chk($sformatf("vec%0d_tail", i), t, vecs[i].x_tail);
        end

        // No credits returned: two flits, then stall until one credit comes back.
        cnt_send = 0;
        cycle(1'b1, 32'h44332211, 1'b0, 2'd2, 4'd9, 1'b0, r, s, dd, t);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 2'd0, 4'd0, 1'b0, r, s, dd, t);
            if (s) cnt_send++;
        end
        chk("stall_flit_count", cnt_send, 2);
        chk("stall_held_ready", r, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 2'd0, 4'd0, 1'b1, r, s, dd, t);
        chk("credit_edge_nosend", s, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 2'd0, 4'd0, 1'b0, r, s, dd, t);
        chk("third_flit_send", s, 1'b1);
        chk("third_flit_data", dd, 8'h33);
        drain();

        // Reset after the second flit discards the beat and restores credits.
        cycle(1'b1, 32'h87654321, 1'b1, 2'd2, 4'd3, 1'b0, r, s, dd, t);
        cycle(1'b0, 32'h0, 1'b0, 2'd0, 4'd0, 1'b0, r, s, dd, t);
        cycle(1'b0, 32'h0, 1'b0, 2'd0, 4'd0, 1'b0, r, s, dd, t);
        chk("pre_reset_flit2", dd, 8'h43);
        rst_noc = 1'b1;
        #2;
        check_reset_outputs("midreset");
        @(negedge clk_noc);
        rst_noc = 1'b0;
        model_reset();
        cycle(1'b0, 32'h0, 1'b0, 2'd0, 4'd0, 1'b0, r, s, dd, t);
        chk("post_reset_no_stale", s, 1'b0);
        cycle(1'b1, 32'h0D0C0B0A, 1'b1, 2'd3, 4'd1, 1'b0, r, s, dd, t);
        cycle(1'b0, 32'h0, 1'b0, 2'd0, 4'd0, 1'b0, r, s, dd, t);
        chk("post_reset_slice0", dd, 8'h0A);
        cycle(1'b0, 32'h0, 1'b0, 2'd0, 4'd0, 1'b0, r, s, dd, t);
        chk("post_reset_credit2", s, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 2'd0, 4'd0, 1'b0, r, s, dd, t);
        chk("post_reset_credit_out", s, 1'b0);
        drain();

        // Back-to-back beats with credits always returned.
        cnt_send = 0;
        cnt_rdy  = 0;
        cycle(1'b1, $urandom, 1'b0, 2'd1, 4'd2, 1'b1, r, s, dd, t);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, $urandom, 1'b1, 2'd1, 4'd2, 1'b1, r, s, dd, t);
            if (s) cnt_send++;
            if (r) cnt_rdy++;
        end
        chk("b2b_flits_in_8", cnt_send, 8);
        chk("b2b_ready_count", cnt_rdy, 2);
        drain();

        // Credit held at 1 by a simultaneous send and return for 100+ beats.
        cnt_send   = 0;
        cnt_acc    = 1;
        cnt_bubble = 0;
        cycle(1'b1, $urandom, 1'b0, 2'd0, 4'd7, 1'b0, r, s, dd, t);
        cycle(1'b0, 32'h0, 1'b0, 2'd0, 4'd0, 1'b0, r, s, dd, t);
        if (s) cnt_send++;
        for (int i = 0; i < 400; i++) begin
            cycle(1'b1, $urandom, 1'($urandom), 2'($urandom), 4'($urandom), 1'b1, r, s, dd, t);
            if (r) cnt_acc++;
            if (s) cnt_send++;
            else cnt_bubble++;
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 2'd0, 4'd0, 1'b1, r, s, dd, t);
            if (s) cnt_send++;
        end
        chk("credit1_no_bubble", cnt_bubble, 0);
        chk("credit1_beats_ge100", (cnt_acc >= 100), 1'b1);
        chk("credit1_no_lost_flit", cnt_send, 4 * cnt_acc);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 3) != 0), $urandom, 1'($urandom), 2'($urandom),
                  4'($urandom), ($urandom_range(0, 2) != 0), r, s, dd, t);
        end

`ifdef AXIS_FLIT_INJECTOR_STATS_EN
        chk("stat_flits_sent", stat_flits_sent, n_sent);
        chk("stat_stall_cycles", stat_stall_cycles, n_stall);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/axis_flit_injector.md
AXIS_FLIT_INJECTOR -- requirements
Module: axis_flit_injector

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 32: AXI-stream payload width.
REQ-002 SHALL have parameter TDEST_WIDTH, default 4: tdest width.
REQ-003 SHALL have parameter TID_WIDTH, default 2: tid width.
REQ-004 SHALL have parameter SERIALIZATION_FACTOR, default 1: flits per beat (1..16); TDATA_WIDTH divisible by it.
REQ-005 SHALL have parameter FLIT_BUFFER_DEPTH, default 1: downstream credits (1..64).
REQ-006 SHALL have derived parameters FLIT_WIDTH = TDATA_WIDTH/SERIALIZATION_FACTOR and DEST_WIDTH = TDEST_WIDTH+TID_WIDTH.
REQ-007 SHALL use one clock and an asynchronous, active-high reset.
REQ-008 SHALL have port clk_noc  input  1  the single clock.
REQ-009 SHALL have port rst_noc  input  1  asynchronous active-high reset.
REQ-010 SHALL have ports axis_in_tvalid/tdata/tlast/tid/tdest  input  1/TDATA_WIDTH/1/TID_WIDTH/TDEST_WIDTH  AXI-stream slave.
REQ-011 SHALL have port axis_in_tready  output  1  slave ready.
REQ-012 SHALL have ports data_out/dest_out  output  FLIT_WIDTH/DEST_WIDTH  flit payload and {tid,tdest}.
REQ-013 SHALL have ports is_tail_out/send_out  output  1/1  tail marker and flit-valid pulse.
REQ-014 SHALL have port credit_in  input  1  one credit returned per high cycle.

Function
REQ-015 SHALL hold a credit counter, $clog2(FLIT_BUFFER_DEPTH+1) bits: -1 per flit launched, +1 per credit_in cycle, unchanged when both occur at the same edge.
REQ-016 SHALL saturate the credit counter at FLIT_BUFFER_DEPTH; excess credit_in ignored.
REQ-017 SHALL implement FSM IDLE, SERIAL: IDLE -> SERIAL on tvalid&tready; SERIAL -> IDLE on last-flit launch with no new beat accepted.
REQ-018 SHALL capture tdata, tlast, {tid,tdest} at the accepting edge and reset flit index to 0.
REQ-019 SHALL launch a flit at each edge in SERIAL where credit counter > 0: register send_out=1, data_out=slice[index] (slice 0 = tdata[FLIT_WIDTH-1:0] first), dest_out=captured dest, index+1.
REQ-020 SHALL register send_out=0 at any edge with no launch; data_out/dest_out/is_tail_out hold their values.
REQ-021 SHALL set is_tail_out=1 only on the last flit (index SERIALIZATION_FACTOR-1) of a beat with tlast=1.
REQ-022 SHALL drive axis_in_tready = IDLE, or (SERIAL and index = SERIALIZATION_FACTOR-1 and credit > 0); a beat accepted with the last-flit launch keeps SERIAL with index 0.
REQ-023 SHALL hold latency from accept edge to send_out high at one cycle when credits are available; sustained throughput one flit per cycle.
REQ-024 SHALL stall in SERIAL with index held while credit = 0; launch resumes the edge after a credit_in.
REQ-025 SHALL, for SERIALIZATION_FACTOR=1, behave as one flit per beat with tready combinational on credit>0 in SERIAL.

Reset
REQ-026 SHALL on rst_noc: FSM IDLE, index 0, credit = FLIT_BUFFER_DEPTH, send_out=0, is_tail_out=0, data_out=0, dest_out=0, axis_in_tready=1 after release.
REQ-027 SHALL discard any partially serialised beat on reset mid-operation; no flit emitted after reset for it.

Configuration
REQ-028 SHALL compile statistics in only when AXIS_FLIT_INJECTOR_STATS_EN is defined: outputs stat_flits_sent (32b, +1 per launch) and stat_stall_cycles (32b, +1 per SERIAL cycle with credit 0), both reset to 0, wrapping modulo 2^32.
REQ-029 SHALL, without AXIS_FLIT_INJECTOR_STATS_EN, omit both ports and counters with data-path behaviour identical.

Verification (TDATA_WIDTH=32, SERIALIZATION_FACTOR=4, FLIT_BUFFER_DEPTH=2 unless noted)
REQ-030 SHALL cover: one beat tdata=0xDDCCBBAA, tlast=1, credit_in returned 1 cycle after each send -> flits 0xAA,0xBB,0xCC,0xDD; is_tail_out only on 0xDD.
REQ-031 SHALL cover: no credit_in returned -> exactly 2 flits sent, send_out then 0; stall holds; one credit_in -> third flit next edge.
REQ-032 SHALL cover: send and credit_in on same edge with credit=1 -> counter stays 1, no lost flit over 100 beats.
REQ-033 SHALL cover: back-to-back beats, credits always returned -> tready high on each 4th flit, 8 flits in 8 consecutive cycles.
REQ-034 SHALL cover: rst_noc asserted after 2nd flit -> send_out 0, credit 2, next beat starts at slice 0.
REQ-035 SHALL cover: with STATS_EN, 3 beats and 5 stall cycles -> stat_flits_sent=12, stat_stall_cycles=5.
